// File: rtl/icache_fetch_unit_pkg.sv
// icache_fetch_unit_pkg: shared widths, address field positions and FSM encoding for the instruction cache
package icache_fetch_unit_pkg;
    localparam int WORD_SIZE  = 16;
    localparam int LINE_WORDS = 4;
    localparam int BLOCK_BITS = 64;
    localparam int NUM_LINES  = 4;
    localparam int OFF_W      = 2;
    localparam int IDX_W      = 2;
    localparam int TAG_W      = 12;
    localparam int OFF_LSB    = 0;
    localparam int IDX_LSB    = 2;
    localparam int TAG_LSB    = 4;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MISS = 1'b1;

    function automatic logic [WORD_SIZE-1:0] sel_word(input logic [BLOCK_BITS-1:0] blk,
                                                      input logic [OFF_W-1:0] off);
        return blk[off*WORD_SIZE +: WORD_SIZE];
    endfunction
endpackage

// File: rtl/icache_line_store.sv
// icache_line_store: valid/tag/data arrays with combinational lookup, synchronous fill and flush
module icache_line_store import icache_fetch_unit_pkg::*; (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WORD_SIZE-1:0]  lookup_addr_i,
    input  logic                  fill_en_i,
    input  logic [IDX_W-1:0]      fill_idx_i,
    input  logic [TAG_W-1:0]      fill_tag_i,
    input  logic [BLOCK_BITS-1:0] fill_data_i,
    input  logic                  flush_i,
    output logic                  hit_o,
    output logic [WORD_SIZE-1:0]  word_o
);
    logic [NUM_LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]      tag_q  [NUM_LINES];
    logic [BLOCK_BITS-1:0] data_q [NUM_LINES];
    logic [IDX_W-1:0]      idx;

    assign idx    = lookup_addr_i[IDX_LSB +: IDX_W];
    assign hit_o  = valid_q[idx] && (tag_q[idx] == lookup_addr_i[TAG_LSB +: TAG_W]);
    assign word_o = sel_word(data_q[idx], lookup_addr_i[OFF_LSB +: OFF_W]);

    // flush overrides a coincident fill: data lands but the line stays invalid
    always_comb begin
        valid_d = valid_q;
        if (fill_en_i) valid_d[fill_idx_i] = 1'b1;
        if (flush_i) valid_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) valid_q <= '0;
        else valid_q <= valid_d;

    always_ff @(posedge clk)
        if (fill_en_i) begin
            tag_q[fill_idx_i]  <= fill_tag_i;
            data_q[fill_idx_i] <= fill_data_i;
        end
endmodule

// File: rtl/icache_fetch_unit.sv
// icache_fetch_unit: direct-mapped read-only instruction cache with fixed-latency block refill
module icache_fetch_unit import icache_fetch_unit_pkg::*; #(
    parameter int MEM_LATENCY = 7
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpu_read,
    input  logic [WORD_SIZE-1:0]  cpu_address,
    output logic [WORD_SIZE-1:0]  cpu_data,
    output logic                  cpu_ready,
    input  logic                  flush,
    output logic                  mem_read,
    output logic [WORD_SIZE-1:0]  mem_address,
    input  logic [BLOCK_BITS-1:0] mem_data,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    logic [0:0]           state_q, state_d;
    logic                 mem_read_q, mem_read_d;
    logic [WORD_SIZE-1:0] mem_address_q, mem_address_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     fill_idx_q, fill_idx_d;
    logic [TAG_W-1:0]     fill_tag_q, fill_tag_d;
    logic [15:0]          hit_count_q, hit_count_d;
    logic [15:0]          miss_count_q, miss_count_d;
    logic                 lookup_hit, hit, miss, done;
    logic [WORD_SIZE-1:0] lookup_word;

    icache_line_store u_store (
        .clk          (clk),
        .reset_n      (reset_n),
        .lookup_addr_i(cpu_address),
        .fill_en_i    (done),
        .fill_idx_i   (fill_idx_q),
        .fill_tag_i   (fill_tag_q),
        .fill_data_i  (mem_data),
        .flush_i      (flush),
        .hit_o        (lookup_hit),
        .word_o       (lookup_word)
    );

    assign hit  = (state_q == IDLE) && cpu_read && lookup_hit;
    assign miss = (state_q == IDLE) && cpu_read && !lookup_hit;
    assign done = (state_q == MISS) && (cnt_q == '0);

    assign cpu_ready   = hit;
    assign cpu_data    = hit ? lookup_word : '0;
    assign mem_read    = mem_read_q;
    assign mem_address = mem_address_q;
    assign hit_count   = hit_count_q;
    assign miss_count  = miss_count_q;

    always_comb begin
        state_d       = miss ? MISS : done ? IDLE : state_q;
        mem_read_d    = miss ? 1'b1 : done ? 1'b0 : mem_read_q;
        mem_address_d = miss ? {cpu_address[WORD_SIZE-1:2], 2'b00} : mem_address_q;
        cnt_d         = miss ? CNT_W'(MEM_LATENCY - 1) :
                        (state_q == MISS && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        fill_idx_d    = miss ? cpu_address[IDX_LSB +: IDX_W] : fill_idx_q;
        fill_tag_d    = miss ? cpu_address[TAG_LSB +: TAG_W] : fill_tag_q;
        hit_count_d   = (hit && hit_count_q != '1) ? hit_count_q + 1'b1 : hit_count_q;
        miss_count_d  = (miss && miss_count_q != '1) ? miss_count_q + 1'b1 : miss_count_q;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q       <= IDLE;
            mem_read_q    <= 1'b0;
            mem_address_q <= '0;
            cnt_q         <= '0;
            fill_idx_q    <= '0;
            fill_tag_q    <= '0;
            hit_count_q   <= '0;
            miss_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            mem_read_q    <= mem_read_d;
            mem_address_q <= mem_address_d;
            cnt_q         <= cnt_d;
            fill_idx_q    <= fill_idx_d;
            fill_tag_q    <= fill_tag_d;
            hit_count_q   <= hit_count_d;
            miss_count_q  <= miss_count_d;
        end
endmodule

// File: tb/tb_icache_fetch_unit.sv
// tb_icache_fetch_unit: scoreboard bench with a fixed-latency block memory model
module tb_icache_fetch_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_read = 1'b0;
    logic [15:0] cpu_address = '0;
    logic [15:0] cpu_data;
    logic        cpu_ready;
    logic        flush = 1'b0;
    logic        mem_read;
    logic [15:0] mem_address;
    logic [63:0] mem_data;
    logic [15:0] hit_count, miss_count;
    int          n_chk = 0, n_pass = 0, mem_edges;
    logic [15:0] sb[$];

    icache_fetch_unit dut (
        .clk(clk), .reset_n(reset_n), .cpu_read(cpu_read), .cpu_address(cpu_address),
        .cpu_data(cpu_data), .cpu_ready(cpu_ready), .flush(flush), .mem_read(mem_read),
        .mem_address(mem_address), .mem_data(mem_data), .hit_count(hit_count),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] blk(input logic [15:0] a);
        logic [63:0] b;
        for (int n = 0; n < 4; n++) b[16*n +: 16] = {a[15:2], 2'(n)} ^ 16'h5a5a;
        if (a[15:2] == 14'h8) b = 64'h6000_0000_0000_0000;
        if (a[15:2] == 14'h9) b = 64'h6200_f41c_6100_1234;
        return b;
    endfunction

    function automatic logic [15:0] word_of(input logic [15:0] a);
        logic [63:0] b;
        b = blk(a);
        return b[16*a[1:0] +: 16];
    endfunction

    // memory presents the block only once mem_read has been seen on six edges
    always @(posedge clk or negedge reset_n)
        if (!reset_n) mem_edges <= 0;
        else mem_edges <= mem_read ? mem_edges + 1 : 0;
    assign mem_data = (mem_read && mem_edges >= 6) ? blk(mem_address) : 64'hbad0_bad0_bad0_bad0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cpu_read = 1'b0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // called at a negedge; waits for cpu_ready, then retires the request on the next edge
    task automatic fetch(input logic [15:0] a, input logic [15:0] exp_maddr,
                         input int exp_cyc, input int exp_mr, input int flush_at);
        int cyc = 0, mr = 0;
        bit served = 0;
        sb.push_back(word_of(a));
        cpu_read = 1'b1;
        cpu_address = a;
        while (cyc < 40) begin
            #1;
            if (mem_read) begin
                if (mr == 0) check("mem_address", mem_address, exp_maddr);
                mr++;
            end
            flush = mem_read && flush_at >= 0 && mr == flush_at;
            if (cpu_ready) begin
                served = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        if (served) check("cpu_data", cpu_data, sb.pop_front());
        else begin
            check("ready_timeout", 0, 1);
            void'(sb.pop_front());
        end
        check("serve_cycles", cyc, exp_cyc);
        check("mem_read_cycles", mr, exp_mr);
        @(negedge clk);
        cpu_read = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        #1;
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_miss_count", miss_count, 0);
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_cpu_data", cpu_data, 0);
        do_reset();
        fetch(16'h0023, 16'h0020, 8, 7, -1);
        check("cold_miss_count", miss_count, 1);
        check("cold_hit_count", hit_count, 1);
        fetch(16'h0024, 16'h0024, 8, 7, -1);
        fetch(16'h0025, 16'h0000, 0, 0, -1);
        fetch(16'h0026, 16'h0000, 0, 0, -1);
        fetch(16'h0027, 16'h0000, 0, 0, -1);
        check("spatial_miss_count", miss_count, 2);
        check("spatial_hit_count", hit_count, 5);
        fetch(16'h0034, 16'h0034, 8, 7, -1);
        fetch(16'h0024, 16'h0024, 8, 7, -1);
        fetch(16'h0023, 16'h0000, 0, 0, -1);
        check("conflict_miss_count", miss_count, 4);
        check("conflict_hit_count", hit_count, 8);
        do_reset();
        fetch(16'h0028, 16'h0028, 16, 14, 7);
        check("flush_miss_count", miss_count, 2);
        check("flush_hit_count", hit_count, 1);
        do_reset();
        cpu_read = 1'b1;
        cpu_address = 16'h0028;
        repeat (3) @(negedge clk);
        check("mid_miss_mem_read", mem_read, 1);
        reset_n = 1'b0;
        #1;
        check("async_mem_read", mem_read, 0);
        check("async_miss_count", miss_count, 0);
        check("async_hit_count", hit_count, 0);
        cpu_read = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        fetch(16'h0028, 16'h0028, 8, 7, -1);
        check("after_rst_miss_count", miss_count, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        fetch(16'h0029, 16'h0028, 8, 7, -1);
        check("idle_flush_miss_count", miss_count, 2);
        check("idle_flush_hit_count", hit_count, 2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
